// File: rtl/mk_pkg.sv
// Shared definitions for the MK command initiator: FSM encodings, core error codes, status layout.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mk_pkg;

    // One-hot FSM encoding
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_ISSUE   = 5'b00010,
        ST_WAIT    = 5'b00100,
        ST_TX_STAT = 5'b01000,
        ST_TX_OP   = 5'b10000
    } mk_state_e;

    // Error codes reported by the MK core alongside resp_done
    localparam logic [1:0] ERR_CMD  = 2'b01;
    localparam logic [1:0] ERR_SIZE = 2'b10;
    localparam logic [1:0] ERR_PRM  = 2'b11;

    // Status byte layout: core error in [1:0], timeout flag in [2]
    localparam int STAT_ERR_LSB = 0;
    localparam int STAT_ERR_MSB = 1;
    localparam int STAT_TMO_BIT = 2;

    localparam logic [7:0] STAT_TMO = 8'h04;

    // Status byte for a completed command carrying core error code err
    function automatic logic [7:0] mk_err_status(input logic [1:0] err);
        logic [7:0] s;
        s = '0;
        s[STAT_ERR_MSB:STAT_ERR_LSB] = err;
        return s;
    endfunction

endpackage

// File: rtl/mk_tmo_cnt.sv
// Completion timeout counter: counts enabled cycles from 0, flags expiry at TMO_CYC-1.
// Latency: expire is a decode of the count register (same cycle as the count value).
// Backpressure: none; saturates at TMO_CYC-1 until cleared.
module mk_tmo_cnt #(
    parameter int unsigned TMO_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: clear wins, otherwise count while enabled and not yet at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != TMO_LAST)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == TMO_LAST);

endmodule

// File: rtl/mk_cmd_init.sv
// MK command initiator: issues one command per L3 request, waits for completion or timeout, returns status+op bytes.
// Latency: cmd_en in the cycle cmd_rdy is seen in ISSUE; first response byte 1 cycle after resp_done/timeout.
// Backpressure: req_rdy only in IDLE; response bytes held stable until rsp_rdy.
import mk_pkg::*;

module mk_cmd_init #(
    parameter int unsigned TMO_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_mk,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [7:0]  req_op,
    input  logic [15:0] req_extend,
    input  logic [15:0] req_size,
    output logic        cmd_en,
    output logic [4:0]  cmd_op,
    output logic [15:0] cmd_extend,
    output logic [15:0] wr_size,
    input  logic        cmd_rdy,
    input  logic        resp_done,
    input  logic [1:0]  resp_err,
    output logic        mk_abort,
    output logic        rsp_vld,
    output logic [7:0]  rsp_data,
    output logic        rsp_last,
    input  logic        rsp_rdy
);

    mk_state_e   state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [15:0] ext_q, ext_d;
    logic [15:0] size_q, size_d;
    logic [7:0]  status_q, status_d;

    logic tmo_en;
    logic tmo_clr;
    logic tmo_expire;

    // Counter only runs in WAIT; it restarts from 0 on every entry
    assign tmo_en  = (state_q == ST_WAIT);
    assign tmo_clr = clr_mk || (state_q != ST_WAIT);

    mk_tmo_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tmo_en),
        .clr    (tmo_clr),
        .expire (tmo_expire)
    );

    // Next-state, field capture and output decode
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ext_d      = ext_q;
        size_d     = size_q;
        status_d   = status_q;
        req_rdy    = 1'b0;
        cmd_en     = 1'b0;
        cmd_op     = '0;
        cmd_extend = '0;
        wr_size    = '0;
        mk_abort   = 1'b0;
        rsp_vld    = 1'b0;
        rsp_data   = '0;
        rsp_last   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Held low while reset is asserted, high immediately after release
                req_rdy = rst_n;
                if (req_vld) begin
                    op_d     = req_op;
                    ext_d    = req_extend;
                    size_d   = req_size;
                    status_d = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cmd_en = cmd_rdy;
                if (cmd_rdy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Completion beats a timeout expiring in the same cycle
                if (resp_done) begin
                    status_d = mk_err_status(resp_err);
                    state_d  = ST_TX_STAT;
                end else if (tmo_expire) begin
                    mk_abort = 1'b1;
                    status_d = STAT_TMO;
                    state_d  = ST_TX_STAT;
                end
            end
            ST_TX_STAT: begin
                rsp_vld  = 1'b1;
                rsp_data = status_q;
                if (rsp_rdy) begin
                    state_d = ST_TX_OP;
                end
            end
            ST_TX_OP: begin
                rsp_vld  = 1'b1;
                rsp_data = op_q;
                rsp_last = 1'b1;
                if (rsp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Command fields are visible from capture until the FSM is back in IDLE
        if (state_q != ST_IDLE) begin
            cmd_op     = op_q[7:3];
            cmd_extend = ext_q;
            wr_size    = size_q;
        end

        // Soft clear overrides everything: no command strobe, no abort, back to IDLE
        if (clr_mk) begin
            state_d  = ST_IDLE;
            status_d = '0;
            cmd_en   = 1'b0;
            mk_abort = 1'b0;
        end
    end

    // State and captured-field registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            ext_q    <= '0;
            size_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            ext_q    <= ext_d;
            size_q   <= size_d;
            status_q <= status_d;
        end
    end

endmodule
